muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; 32 is the only supported value.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req_valid  input  1  EX-stage instruction is an M-extension op; held stable while stall_o=1.
REQ-005 SHALL have port: funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port: in_a, in_b  input  32 each  forwarded rs1/rs2 operands.
REQ-007 SHALL have port: flush  input  1  EX flush from hazard unit; kills the in-flight op.
REQ-008 SHALL have port: stall_o  output  1  stall request to hazard unit; holds IF/ID/EX.
REQ-009 SHALL have port: result_valid  output  1  one-cycle pulse; result is valid.
REQ-010 SHALL have port: result  output  32  product/quotient/remainder to be muxed over aluresult.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE & req_valid & ~flush (cycle T) SHALL latch operands, funct3 and sign info, and go to CALC with count=0; special cases and (with macro) multiply SHALL go to DONE instead.
REQ-013 CALC SHALL do one radix-2 step per cycle over unsigned magnitudes: shift-add multiply (64-bit product) or restoring divide (33-bit partial remainder); count increments mod 32.
REQ-014 CALC with count=31 SHALL go to DONE, so DONE is reached at T+33.
REQ-015 DONE SHALL drive result_valid=1 for exactly one cycle and go to IDLE unconditionally; req_valid in DONE SHALL NOT start a new op.
REQ-016 stall_o SHALL equal req_valid & (state != DONE) & ~flush, combinationally; iterative ops stall cycles T..T+32 (33 cycles).
REQ-017 Sign handling: negate operands per funct3 signedness; negate quotient if signs differ; remainder takes dividend sign; MULH/MULHSU/MULHU return product[63:32], MUL returns product[31:0].
REQ-018 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = in_a, via IDLE->DONE (result_valid at T+1).
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0, via IDLE->DONE.
REQ-020 result SHALL stay stable from DONE until the next op is accepted; it is 0 after reset.
REQ-021 flush in any state SHALL force IDLE next cycle with no result_valid; flush has priority over req_valid and over DONE.
REQ-022 After a flush at cycle F, a new req_valid SHALL be accepted at F+1.

Reset
REQ-023 rst=1 SHALL force, on the next posedge, state=IDLE, count=0, result=0, result_valid=0, and clear all operand/accumulator registers.
REQ-024 rst asserted mid-CALC SHALL abandon the op with no result_valid; rst has priority over flush and req_valid.
REQ-025 stall_o SHALL be 0 while rst=1.

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-027 MULDIV_FAST_MUL_EN defined: multiplies SHALL use a single-cycle 33x33 signed multiplier and go IDLE->DONE (result_valid at T+1, stall 1 cycle).
REQ-028 MULDIV_FAST_MUL_EN undefined: multiplies SHALL use the iterative CALC path (result_valid at T+33); divide behaviour SHALL be identical in both builds.

Verification
REQ-029 DIV in_a=100, in_b=7 at T -> stall_o=1 T..T+32, result_valid at T+33, result=14; REM same operands -> 2.
REQ-030 REM in_a=0xFFFFFFF9 (-7), in_b=2 -> result 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
REQ-031 DIVU in_a=0x1234, in_b=0 -> result_valid at T+1, result 0xFFFFFFFF; REMU same operands -> 0x1234.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same operands -> 0.
REQ-033 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; result_valid at T+1 with macro, T+33 without.
REQ-034 DIVU started at T, flush at T+10 -> stall_o=0 at T+10, no result_valid, new DIVU 9/3 accepted at T+11 -> result 3 at T+44; repeat the sequence using rst in place of flush.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one radix-2 step per cycle, 33-cycle ops, special divides in 1 cycle.
// Latency: result_valid at T+33 for iterative ops, T+1 for divide-by-zero, signed overflow and fast multiplies.
// Backpressure: stall_o holds IF/ID/EX while an op is pending; optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            stall_o,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [4:0]      count;
  logic [2:0]      funct3_q;
  logic            neg_res;   // negate product or quotient at the end
  logic            neg_rem;   // remainder takes the dividend's sign
  logic [XLEN-1:0] acc_hi;    // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;    // multiplier bits / dividend-then-quotient bits
  logic [XLEN-1:0] opb;       // multiplicand / divisor magnitude

  // ---------------- request decode (cycle T) ----------------
  logic            sign_a, sign_b, a_neg, b_neg, is_div;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            fast_take;
  logic [XLEN-1:0] fast_res;

  // Operand signedness, magnitudes and single-cycle divide special cases
  always_comb begin
    sign_a   = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
               (funct3 == F_DIV)  || (funct3 == F_REM);
    sign_b   = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg    = sign_a & in_a[XLEN-1];
    b_neg    = sign_b & in_b[XLEN-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    is_div   = funct3[2];
    div_zero = is_div && (in_b == '0);
    div_ovf  = is_div && !funct3[0] && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
    if (div_zero)
      special_res = funct3[1] ? in_a : 32'hFFFF_FFFF;
    else
      special_res = funct3[1] ? 32'h0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fast_a, fast_b;
  logic [2*XLEN-1:0]    fast_prod;

  // Single-cycle 33x33 signed multiply; the extra bit carries per-operand signedness
  always_comb begin
    fast_a    = {sign_a & in_a[XLEN-1], in_a};
    fast_b    = {sign_b & in_b[XLEN-1], in_b};
    fast_prod = 64'(fast_a * fast_b);
    fast_take = !is_div;
    fast_res  = (funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  // Multiplies always take the iterative path in this build
  always_comb begin
    fast_take = 1'b0;
    fast_res  = '0;
  end
`endif

  // ---------------- one radix-2 step (CALC) ----------------
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] q_fin, r_fin, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  // Shift-add multiply step or restoring divide step, plus the signed fix-up on the last step
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    ge      = shifted >= {1'b0, opb};
    if (funct3_q[2]) begin
      step_hi = ge ? 32'(shifted - {1'b0, opb}) : shifted[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], ge};
    end else begin
      step_hi = add_sum[XLEN:1];
      step_lo = {add_sum[0], acc_lo[XLEN-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_s = neg_res ? -prod : prod;
    q_fin  = neg_res ? -step_lo : step_lo;
    r_fin  = neg_rem ? -step_hi : step_hi;
    if (funct3_q[2])
      final_res = funct3_q[1] ? r_fin : q_fin;
    else
      final_res = (funct3_q == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // Stall the front end while an op is pending; DONE releases it, flush/reset drop it
  assign stall_o = req_valid & (state != DONE) & ~flush & ~rst;

  // Sequencer FSM with registered result and result_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      funct3_q     <= '0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opb          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              funct3_q <= funct3;
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              opb      <= b_mag;
              count    <= '0;
              if (div_zero || div_ovf) begin
                result       <= special_res;
                result_valid <= 1'b1;
                state        <= DONE;
              end else if (fast_take) begin
                result       <= fast_res;
                result_valid <= 1'b1;
                state        <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
              result       <= final_res;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
